mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 139 +++++++++++++
 tb/tb_mdu.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// rtl/mdu.sv - multiply/divide unit with HI/LO result registers and fixed latency
// The result is computed at acceptance and held until the latency counter expires.
module mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;

    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic                      b_zero, div_ovf;
    logic        [WIDTH-1:0]   b_safe_s, b_safe_u, one_w;
    logic signed [WIDTH-1:0]   quo_s, rem_s;
    logic        [WIDTH-1:0]   quo_u, rem_u;

    assign one_w   = {{(WIDTH-1){1'b0}}, 1'b1};
    assign prod_s  = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
    assign prod_u  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    assign b_zero  = (B == '0);
    assign div_ovf = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);

    // Divider inputs are steered away from /0 and MIN/-1 so the arithmetic is always defined.
    assign b_safe_s = (b_zero || div_ovf) ? one_w : B;
    assign b_safe_u = b_zero ? one_w : B;
    assign quo_s    = $signed(A) / $signed(b_safe_s);
    assign rem_s    = $signed(A) % $signed(b_safe_s);
    assign quo_u    = A / b_safe_u;
    assign rem_u    = A % b_safe_u;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (OP)
                        OP_MULT: begin
                            res_hi_d = prod_s[2*WIDTH-1:WIDTH];
                            res_lo_d = prod_s[WIDTH-1:0];
                            cnt_d    = CNT_W'(MUL_CYCLES);
                            state_d  = S_BUSY;
                        end
                        OP_MULTU: begin
                            res_hi_d = prod_u[2*WIDTH-1:WIDTH];
                            res_lo_d = prod_u[WIDTH-1:0];
                            cnt_d    = CNT_W'(MUL_CYCLES);
                            state_d  = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b_zero) begin
                                res_hi_d = A;
                                res_lo_d = '1;
                            end else if (OP == OP_DIV && div_ovf) begin
                                res_hi_d = '0;
                                res_lo_d = A;
                            end else if (OP == OP_DIV) begin
                                res_hi_d = rem_s;
                                res_lo_d = quo_s;
                            end else begin
                                res_hi_d = rem_u;
                                res_lo_d = quo_u;
                            end
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = S_BUSY;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - randomized self-checking bench for mdu against an arithmetic reference model
module tb_mdu;

    localparam int W    = 32;
    localparam int NMUL = 5;
    localparam int NDIV = 10;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   OP;
    logic [W-1:0] A, B;
    logic         busy;
    logic [W-1:0] HI, LO;

    int tests;
    int fails;
    logic [W-1:0] hi_m, lo_m;

    mdu #(.WIDTH(W), .MUL_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .OP   (OP),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: result values from plain integer arithmetic, latency from the op class.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eh, output logic [W-1:0] el, output int n);
        longint      ps;
        logic [63:0] pu;
        int          ia, ib;
        eh = hi_m; el = lo_m; n = 0;
        ia = $signed(a); ib = $signed(b);
        case (op)
            3'd0: begin ps = longint'(ia) * longint'(ib); eh = ps[63:32]; el = ps[31:0]; n = NMUL; end
            3'd1: begin pu = 64'(a) * 64'(b); eh = pu[63:32]; el = pu[31:0]; n = NMUL; end
            3'd2: begin
                n = NDIV;
                if (b == 0) begin el = '1; eh = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin el = a; eh = 0; end
                else begin el = ia / ib; eh = ia % ib; end
            end
            3'd3: begin
                n = NDIV;
                if (b == 0) begin el = '1; eh = a; end
                else begin el = a / b; eh = a % b; end
            end
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
    endtask

    // Drives one request from a negedge; returns at the negedge after completion.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit noisy);
        logic [W-1:0] eh, el;
        int n, cyc;
        model(op, a, b, eh, el, n);
        start = 1'b1; OP = op; A = a; B = b;
        @(negedge clk);
        cyc = 0;
        if (n > 0) begin
            while (busy === 1'b1 && cyc < n + 4) begin
                check_eq("hold_hi", 64'(HI), 64'(hi_m));
                check_eq("hold_lo", 64'(LO), 64'(lo_m));
                cyc++;
                if (noisy) begin
                    start = 1'b1; OP = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
            check_eq("busy_cycles", 64'(cyc), 64'(n));
        end
        start = 1'b0;
        hi_m = eh; lo_m = el;
        check_eq("busy_idle", 64'(busy), 64'(0));
        check_eq("hi", 64'(HI), 64'(hi_m));
        check_eq("lo", 64'(LO), 64'(lo_m));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        tests = 0; fails = 0;
        hi_m = '0; lo_m = '0;
        reset = 1'b1; start = 1'b0; OP = '0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_hi", 64'(HI), 64'(0));
        check_eq("rst_lo", 64'(LO), 64'(0));

        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check_eq("multu_hi_const", 64'(HI), 64'h1);
        check_eq("multu_lo_const", 64'(LO), 64'hFFFF_FFFE);
        do_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check_eq("mult_lo_const", 64'(LO), 64'hFFFF_FFEB);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_eq("div_lo_const", 64'(LO), 64'hFFFF_FFFD);
        check_eq("div_hi_const", 64'(HI), 64'hFFFF_FFFF);
        do_op(3'd3, 32'd5, 32'd0, 1'b0);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(3'd4, 32'h1234, 32'd0, 1'b0);
        do_op(3'd5, 32'h5678, 32'd0, 1'b0);
        check_eq("mthi_const", 64'(HI), 64'h1234);
        do_op(3'd6, 32'hDEAD, 32'hBEEF, 1'b0);
        do_op(3'd7, 32'hDEAD, 32'hBEEF, 1'b0);
        do_op(3'd2, 32'd100, 32'd7, 1'b1);

        for (int i = 0; i < 60; i++)
            do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));

        // abort a divide on its fourth busy cycle
        do_op(3'd0, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0);
        start = 1'b1; OP = 3'd2; A = 32'd1000; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hi_m = '0; lo_m = '0;
        check_eq("abort_busy", 64'(busy), 64'(0));
        check_eq("abort_hi", 64'(HI), 64'(0));
        check_eq("abort_lo", 64'(LO), 64'(0));
        repeat (15) @(negedge clk);
        check_eq("abort_late_hi", 64'(HI), 64'(0));
        check_eq("abort_late_lo", 64'(LO), 64'(0));
        check_eq("abort_late_busy", 64'(busy), 64'(0));

        // reset beats a simultaneous request
        reset = 1'b1; start = 1'b1; OP = 3'd4; A = 32'hCAFE;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check_eq("rst_start_hi", 64'(HI), 64'(0));
        check_eq("rst_start_busy", 64'(busy), 64'(0));

        do_op(3'd3, 32'd17, 32'd5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
